// File: rtl/iic_pkg.sv
// Purpose : shared FSM state encoding and default timing constants for the IIC EEPROM arbiter.
// Latency : n/a (constants only).
// Backpressure: n/a.
package iic_pkg;

    // FSM state encoding (plain constants so older tools and netlists can read it)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY     = 2'd1;
    localparam logic [1:0] ST_RECOVER  = 2'd2;
    localparam logic [1:0] ST_TWR_WAIT = 2'd3;

    // Defaults at 50 MHz: 5 ms write cycle, 40 ms transaction timeout, 4-cycle master reset
    localparam int TWR_CYCLES_DEF     = 250000;
    localparam int TIMEOUT_CYCLES_DEF = 2000000;
    localparam int RST_CYCLES_DEF     = 4;

    // Largest of three limits; sizes the single shared down-counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/iic_eeprom_arbiter.sv
// Purpose : round-robin arbiter sharing one IIC EEPROM master between two requesters.
// Latency : command rises 1 cycle after accept; reqN_done pulses 1 cycle after done_sig.
// Backpressure: reqN_ready is high only in IDLE for the selected requester; one transaction in flight.
//
// Ports:
//   clk_50M, rst_n             clock, synchronous active-low reset
//   reqN_valid/we/addr/wdata   requester N transaction (N = 0, 1)
//   reqN_ready                 combinational accept (valid & ready)
//   reqN_done/rdata/err        one-cycle completion pulse with read data and timeout flag
//   wr_sig, rd_sig             level commands to the IIC master
//   addr_sig, wr_data          command operands, stable while a command is high
//   rd_data, done_sig          IIC master result and completion pulse
//   iic_rst_n                  active-low reset to the IIC master
module iic_eeprom_arbiter
    import iic_pkg::*;
#(
    parameter int TWR_CYCLES     = TWR_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int RST_CYCLES     = RST_CYCLES_DEF
) (
    input  logic       clk_50M,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic       req0_we,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,

    input  logic       req1_valid,
    input  logic       req1_we,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,

    output logic       wr_sig,
    output logic       rd_sig,
    output logic [7:0] addr_sig,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    input  logic       done_sig,
    output logic       iic_rst_n
);

    localparam int CNT_MAX = max3(TWR_CYCLES, TIMEOUT_CYCLES, RST_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWR     = CNT_W'(TWR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(RST_CYCLES);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;          // shared down-counter: timeout, recovery, write-cycle wait
    logic             last_grant;   // requester granted most recently
    logic             owner;        // requester owning the in-flight transaction
    logic             cur_we;
    logic             sel;
    logic             idle;
    logic             grant_vld;
    logic             cnt_last;     // counter is on its final cycle (<=1 so a zero limit cannot wrap)

    assign idle     = (state == ST_IDLE);
    assign cnt_last = (cnt <= CNT_ONE);

    // Round-robin selection: a lone requester wins outright; when both are
    // pending the one not granted last wins.
    always_comb begin
        sel = ~last_grant;
        if (req0_valid && !req1_valid) begin
            sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = idle && !sel;
    assign req1_ready = idle && sel;
    assign grant_vld  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cur_we     <= 1'b0;
            wr_sig     <= 1'b0;
            rd_sig     <= 1'b0;
            addr_sig   <= 8'h00;
            wr_data    <= 8'h00;
            iic_rst_n  <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= 8'h00;
            req0_err   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= 8'h00;
            req1_err   <= 1'b0;
        end else begin
            // Completion outputs are single-cycle; the master reset is released by default
            req0_done  <= 1'b0;
            req0_rdata <= 8'h00;
            req0_err   <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= 8'h00;
            req1_err   <= 1'b0;
            iic_rst_n  <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner      <= sel;
                        last_grant <= sel;
                        cur_we     <= sel ? req1_we : req0_we;
                        addr_sig   <= sel ? req1_addr : req0_addr;
                        wr_data    <= sel ? req1_wdata : req0_wdata;
                        wr_sig     <= sel ? req1_we : req0_we;
                        rd_sig     <= sel ? !req1_we : !req0_we;
                        cnt        <= CNT_TIMEOUT;
                        state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // done_sig is checked first so a completion on the timeout cycle succeeds
                    if (done_sig) begin
                        wr_sig <= 1'b0;
                        rd_sig <= 1'b0;
                        if (owner) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= cur_we ? 8'h00 : rd_data;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= cur_we ? 8'h00 : rd_data;
                        end
                        if (cur_we) begin
                            cnt   <= CNT_TWR;
                            state <= ST_TWR_WAIT;
                        end else begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else if (cnt_last) begin
                        wr_sig    <= 1'b0;
                        rd_sig    <= 1'b0;
                        iic_rst_n <= 1'b0;
                        cnt       <= CNT_RST;
                        state     <= ST_RECOVER;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_RECOVER: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= 1'b1;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 1'b1;
                        end
                    end else begin
                        iic_rst_n <= 1'b0;
                        cnt       <= cnt - CNT_ONE;
                    end
                end

                ST_TWR_WAIT: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_eeprom_arbiter.sv
// Purpose : directed self-checking bench for iic_eeprom_arbiter with a scripted IIC master.
// Latency : inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: master completion is driven step by step from the stimulus sequence.
module tb_iic_eeprom_arbiter;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       wr_sig, rd_sig, done_sig, iic_rst_n;
    logic [7:0] addr_sig, wr_data, rd_data;

    int checks = 0;
    int errors = 0;

    always #10 clk_50M = ~clk_50M;

    iic_eeprom_arbiter #(
        .TWR_CYCLES     (100),
        .TIMEOUT_CYCLES (5000),
        .RST_CYCLES     (4)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .wr_sig     (wr_sig),
        .rd_sig     (rd_sig),
        .addr_sig   (addr_sig),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .done_sig   (done_sig),
        .iic_rst_n  (iic_rst_n)
    );

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Master completes in the cycle after these inputs are set
    task automatic master_done(input logic [7:0] data);
        rd_data  = data;
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        rd_data  = 8'h00;
    endtask

    int seen_ready;
    int low_cnt;
    int guard;
    logic exp_owner;

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        rd_data    = 8'h00;
        done_sig   = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cmd",     {14'd0, wr_sig, rd_sig}, 16'h0000);
        chk("rst_addr",    {addr_sig, wr_data}, 16'h0000);
        chk("rst_iic_low", {15'd0, iic_rst_n}, 16'h0000);
        chk("rst_done",    {12'd0, req0_done, req1_done, req0_err, req1_err}, 16'h0000);
        chk("rst_rdata",   {req0_rdata, req1_rdata}, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("rst_iic_rel", {15'd0, iic_rst_n}, 16'h0001);

        // ---------------- req0 write 0x5A @ 0x10 ----------------
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'h5A;
        #1;
        chk("wr_ready", {14'd0, req1_ready, req0_ready}, 16'h0001);
        tick();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        chk("wr_cmd",      {14'd0, wr_sig, rd_sig}, 16'h0002);
        chk("wr_operands", {addr_sig, wr_data}, 16'h105A);
        chk("wr_busy_rdy", {14'd0, req1_ready, req0_ready}, 16'h0000);
        tick();
        chk("wr_hold",     {6'd0, wr_sig, rd_sig, addr_sig}, 16'h0210);
        master_done(8'hEE);
        chk("wr_done",     {13'd0, req0_done, req0_err, req1_done}, 16'h0004);
        chk("wr_rdata",    {8'd0, req0_rdata}, 16'h0000);
        chk("wr_cmd_drop", {14'd0, wr_sig, rd_sig}, 16'h0000);
        // done-pulse cycle is the first of 100 write-cycle wait cycles
        seen_ready = 0;
        for (int i = 0; i < 100; i++) begin
            if (req0_ready || req1_ready) seen_ready++;
            if (i < 99) tick();
        end
        chk("twr_no_ready", seen_ready[15:0], 16'd0);
        tick();
        chk("twr_end_rdy", {15'd0, req0_ready | req1_ready}, 16'h0001);

        // ---------------- req1 read @ 0x10 -> 0xA5 ----------------
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h10;
        #1;
        chk("rd_ready", {14'd0, req1_ready, req0_ready}, 16'h0002);
        tick();
        req1_valid = 1'b0; req1_addr = 8'h00;
        chk("rd_cmd",  {6'd0, wr_sig, rd_sig, addr_sig}, 16'h0110);
        tick();
        master_done(8'hA5);
        chk("rd_done",  {14'd0, req1_done, req0_done}, 16'h0002);
        chk("rd_data",  {7'd0, req1_err, req1_rdata}, 16'h00A5);
        chk("rd_drop",  {14'd0, wr_sig, rd_sig}, 16'h0000);
        chk("rd_rdy_again", {15'd0, req0_ready | req1_ready}, 16'h0001);

        // ---------------- done_sig outside BUSY is ignored ----------------
        tick();
        master_done(8'h77);
        chk("idle_done_ign", {12'd0, req0_done, req1_done, wr_sig, rd_sig}, 16'h0000);
        chk("idle_rdata",    {req0_rdata, req1_rdata}, 16'h0000);

        // ---------------- simultaneous requests after reset alternate ----------------
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = i[0];
            chk("arb_ready", {14'd0, req1_ready, req0_ready}, exp_owner ? 16'h0002 : 16'h0001);
            tick();
            chk("arb_addr", {8'd0, addr_sig}, exp_owner ? 16'h0002 : 16'h0001);
            tick();
            master_done(8'h40 + 8'(i));
            chk("arb_done", {14'd0, req1_done, req0_done}, exp_owner ? 16'h0002 : 16'h0001);
            chk("arb_rdata", {8'd0, exp_owner ? req1_rdata : req0_rdata}, 16'h0040 + 16'(i));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 8'h00; req1_addr = 8'h00;

        // ---------------- timeout and recovery on req0 read ----------------
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h33;
        #1;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 4999; i++) tick();
        chk("to_cmd_last", {14'd0, wr_sig, rd_sig}, 16'h0001);
        tick();
        chk("to_cmd_drop", {14'd0, wr_sig, rd_sig}, 16'h0000);
        low_cnt = 0;
        guard = 0;
        while (!req0_done && guard < 20) begin
            if (!iic_rst_n) low_cnt++;
            tick();
            guard++;
        end
        chk("to_rst_low_cycles", low_cnt[15:0], 16'd4);
        chk("to_done_err", {13'd0, req0_done, req0_err, iic_rst_n}, 16'h0007);
        chk("to_rdata", {8'd0, req0_rdata}, 16'h0000);

        // ---------------- done on the timeout cycle wins ----------------
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h44;
        #1;
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4999; i++) tick();
        chk("race_cmd", {14'd0, wr_sig, rd_sig}, 16'h0001);
        master_done(8'h3C);
        chk("race_done", {13'd0, req1_done, req1_err, iic_rst_n}, 16'h0005);
        chk("race_rdata", {8'd0, req1_rdata}, 16'h003C);
        tick();
        chk("race_no_recover", {14'd0, iic_rst_n, req0_ready | req1_ready}, 16'h0003);

        // ---------------- reset mid-read ----------------
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h55;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("mid_rd_active", {14'd0, wr_sig, rd_sig}, 16'h0001);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cmd",  {14'd0, wr_sig, rd_sig}, 16'h0000);
        chk("mid_rst_done", {14'd0, req0_done, req1_done}, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_after", {13'd0, iic_rst_n, req0_done, req1_done}, 16'h0004);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 8'h01; req1_addr = 8'h02;
        #1;
        chk("mid_rst_prio", {14'd0, req1_ready, req0_ready}, 16'h0001);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
